// File: rtl/idex_latch.sv
// Decode/execute pipeline register with stall, flush, halt freeze and a saturating bubble counter.
// Optional load-use bubble insertion is compiled in when IDEX_LOADUSE_DETECT_EN is defined.
module idex_latch #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             stall,
    input  logic             flush,
    input  logic [5:0]       id_opfunc,
    input  logic [1:0]       id_RegDst,
    input  logic [1:0]       id_MemtoReg,
    input  logic [3:0]       id_ALUOp,
    input  logic [1:0]       id_ExtOp,
    input  logic             id_ALUSrc,
    input  logic             id_RegWEN,
    input  logic             id_dWENi,
    input  logic             id_dRENi,
    input  logic             id_halt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_shamt,
    input  logic [15:0]      id_imm,
    input  logic [31:0]      id_busA,
    input  logic [31:0]      id_busB,
    input  logic [31:0]      id_npc,
    output logic [5:0]       ex_opfunc,
    output logic [1:0]       ex_RegDst,
    output logic [1:0]       ex_MemtoReg,
    output logic [3:0]       ex_ALUOp,
    output logic [1:0]       ex_ExtOp,
    output logic             ex_ALUSrc,
    output logic             ex_RegWEN,
    output logic             ex_dWENi,
    output logic             ex_dRENi,
    output logic             ex_halt,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_shamt,
    output logic [15:0]      ex_imm,
    output logic [31:0]      ex_busA,
    output logic [31:0]      ex_busB,
    output logic [31:0]      ex_npc,
    output logic             ex_valid,
    output logic             lu_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic [5:0]  opfunc;
        logic [1:0]  RegDst;
        logic [1:0]  MemtoReg;
        logic [3:0]  ALUOp;
        logic [1:0]  ExtOp;
        logic        ALUSrc;
        logic        RegWEN;
        logic        dWENi;
        logic        dRENi;
        logic        halt;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [31:0] busA;
        logic [31:0] busB;
        logic [31:0] npc;
    } idex_t;

    idex_t            r_ex;
    idex_t            w_id;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_frozen;
    logic             w_advance;
    logic             w_lu_stall;
    logic             w_bubble;
    logic             w_capture;

    always_comb begin
        w_id          = '0;
        w_id.opfunc   = id_opfunc;
        w_id.RegDst   = id_RegDst;
        w_id.MemtoReg = id_MemtoReg;
        w_id.ALUOp    = id_ALUOp;
        w_id.ExtOp    = id_ExtOp;
        w_id.ALUSrc   = id_ALUSrc;
        w_id.RegWEN   = id_RegWEN;
        w_id.dWENi    = id_dWENi;
        w_id.dRENi    = id_dRENi;
        w_id.halt     = id_halt;
        w_id.rt       = id_rt;
        w_id.rd       = id_rd;
        w_id.shamt    = id_shamt;
        w_id.imm      = id_imm;
        w_id.busA     = id_busA;
        w_id.busB     = id_busB;
        w_id.npc      = id_npc;
    end

`ifdef IDEX_LOADUSE_DETECT_EN
    // A load in EX whose destination feeds the instruction in ID needs one bubble.
    assign w_lu_stall = ~flush & r_valid & r_ex.dRENi & (r_ex.rt != 5'd0) &
                        ((r_ex.rt == id_rs) | (r_ex.rt == id_rt));
`else
    logic w_unused_rs;
    assign w_unused_rs = ^id_rs;
    assign w_lu_stall  = 1'b0;
`endif

    assign w_frozen  = r_valid & r_ex.halt;
    assign w_advance = ~w_frozen & en & ~stall;
    assign w_bubble  = flush | (w_advance & w_lu_stall);
    assign w_capture = ~flush & w_advance & ~w_lu_stall;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ex    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_bubble) begin
                r_ex    <= '0;
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_ex    <= w_id;
                r_valid <= 1'b1;
            end
            if (w_bubble && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign ex_opfunc   = r_ex.opfunc;
    assign ex_RegDst   = r_ex.RegDst;
    assign ex_MemtoReg = r_ex.MemtoReg;
    assign ex_ALUOp    = r_ex.ALUOp;
    assign ex_ExtOp    = r_ex.ExtOp;
    assign ex_ALUSrc   = r_ex.ALUSrc;
    assign ex_RegWEN   = r_ex.RegWEN;
    assign ex_dWENi    = r_ex.dWENi;
    assign ex_dRENi    = r_ex.dRENi;
    assign ex_halt     = r_ex.halt;
    assign ex_rt       = r_ex.rt;
    assign ex_rd       = r_ex.rd;
    assign ex_shamt    = r_ex.shamt;
    assign ex_imm      = r_ex.imm;
    assign ex_busA     = r_ex.busA;
    assign ex_busB     = r_ex.busB;
    assign ex_npc      = r_ex.npc;
    assign ex_valid    = r_valid;
    assign lu_stall    = w_lu_stall;
    assign bubble_cnt  = r_cnt;

endmodule

// File: tb/tb_idex_latch.sv
// Randomized self-checking bench for idex_latch against a rule-based reference model.
module tb_idex_latch;

    logic        CLK = 1'b0;
    logic        nRST, en, stall, flush;
    logic [5:0]  id_opfunc;
    logic [1:0]  id_RegDst, id_MemtoReg, id_ExtOp;
    logic [3:0]  id_ALUOp;
    logic        id_ALUSrc, id_RegWEN, id_dWENi, id_dRENi, id_halt;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm;
    logic [31:0] id_busA, id_busB, id_npc;

    logic [5:0]  ex_opfunc, s_opfunc;
    logic [1:0]  ex_RegDst, ex_MemtoReg, ex_ExtOp, s_RegDst, s_MemtoReg, s_ExtOp;
    logic [3:0]  ex_ALUOp, s_ALUOp;
    logic        ex_ALUSrc, ex_RegWEN, ex_dWENi, ex_dRENi, ex_halt;
    logic        s_ALUSrc, s_RegWEN, s_dWENi, s_dRENi, s_halt;
    logic [4:0]  ex_rt, ex_rd, ex_shamt, s_rt, s_rd, s_shamt;
    logic [15:0] ex_imm, s_imm;
    logic [31:0] ex_busA, ex_busB, ex_npc, s_busA, s_busB, s_npc;
    logic        ex_valid, lu_stall, s_valid, s_lu_stall;
    logic [15:0] bubble_cnt;
    logic [1:0]  s_bubble_cnt;

    always #5 CLK = ~CLK;

    idex_latch #(.CNT_W(16)) u_dut (
        .CLK(CLK), .nRST(nRST), .en(en), .stall(stall), .flush(flush),
        .id_opfunc(id_opfunc), .id_RegDst(id_RegDst), .id_MemtoReg(id_MemtoReg),
        .id_ALUOp(id_ALUOp), .id_ExtOp(id_ExtOp), .id_ALUSrc(id_ALUSrc),
        .id_RegWEN(id_RegWEN), .id_dWENi(id_dWENi), .id_dRENi(id_dRENi), .id_halt(id_halt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_imm(id_imm),
        .id_busA(id_busA), .id_busB(id_busB), .id_npc(id_npc),
        .ex_opfunc(ex_opfunc), .ex_RegDst(ex_RegDst), .ex_MemtoReg(ex_MemtoReg),
        .ex_ALUOp(ex_ALUOp), .ex_ExtOp(ex_ExtOp), .ex_ALUSrc(ex_ALUSrc),
        .ex_RegWEN(ex_RegWEN), .ex_dWENi(ex_dWENi), .ex_dRENi(ex_dRENi), .ex_halt(ex_halt),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_imm(ex_imm),
        .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_npc(ex_npc),
        .ex_valid(ex_valid), .lu_stall(lu_stall), .bubble_cnt(bubble_cnt)
    );

    idex_latch #(.CNT_W(2)) u_sat (
        .CLK(CLK), .nRST(nRST), .en(en), .stall(stall), .flush(flush),
        .id_opfunc(id_opfunc), .id_RegDst(id_RegDst), .id_MemtoReg(id_MemtoReg),
        .id_ALUOp(id_ALUOp), .id_ExtOp(id_ExtOp), .id_ALUSrc(id_ALUSrc),
        .id_RegWEN(id_RegWEN), .id_dWENi(id_dWENi), .id_dRENi(id_dRENi), .id_halt(id_halt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_imm(id_imm),
        .id_busA(id_busA), .id_busB(id_busB), .id_npc(id_npc),
        .ex_opfunc(s_opfunc), .ex_RegDst(s_RegDst), .ex_MemtoReg(s_MemtoReg),
        .ex_ALUOp(s_ALUOp), .ex_ExtOp(s_ExtOp), .ex_ALUSrc(s_ALUSrc),
        .ex_RegWEN(s_RegWEN), .ex_dWENi(s_dWENi), .ex_dRENi(s_dRENi), .ex_halt(s_halt),
        .ex_rt(s_rt), .ex_rd(s_rd), .ex_shamt(s_shamt), .ex_imm(s_imm),
        .ex_busA(s_busA), .ex_busB(s_busB), .ex_npc(s_npc),
        .ex_valid(s_valid), .lu_stall(s_lu_stall), .bubble_cnt(s_bubble_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: what the EX stage should hold, kept as the captured ID word.
    logic [147:0] m_word;
    logic         m_valid, m_halt, m_dren;
    logic [4:0]   m_rt;
    int           m_cnt;
    logic [147:0] saved_word;
    int           cnt_before;

    wire [147:0] got_word = {ex_opfunc, ex_RegDst, ex_MemtoReg, ex_ALUOp, ex_ExtOp, ex_ALUSrc,
                             ex_RegWEN, ex_dWENi, ex_dRENi, ex_halt, ex_rt, ex_rd, ex_shamt,
                             ex_imm, ex_busA, ex_busB, ex_npc};

    function automatic logic [147:0] id_word();
        return {id_opfunc, id_RegDst, id_MemtoReg, id_ALUOp, id_ExtOp, id_ALUSrc,
                id_RegWEN, id_dWENi, id_dRENi, id_halt, id_rt, id_rd, id_shamt,
                id_imm, id_busA, id_busB, id_npc};
    endfunction

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_lu();
`ifdef IDEX_LOADUSE_DETECT_EN
        return !flush && m_valid && m_dren && (m_rt != 5'd0) && (m_rt == id_rs || m_rt == id_rt);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_bubble();
        m_word  = '0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        m_dren  = 1'b0;
        m_rt    = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".word"},  got_word, m_word);
        chk({tag, ".valid"}, ex_valid, m_valid);
        chk({tag, ".cnt16"}, bubble_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
        chk({tag, ".cnt2"},  s_bubble_cnt, (m_cnt > 3) ? 3 : m_cnt);
        chk({tag, ".svalid"}, s_valid, m_valid);
    endtask

    // One clock: check lu_stall on current inputs, decide the rule, then check the result.
    task automatic tick(input string tag);
        logic         lu, bub, cap;
        logic [147:0] w;
        #1;
        lu = model_lu();
        chk({tag, ".lu"}, lu_stall, lu);
        bub = 1'b0;
        cap = 1'b0;
        if (flush)                          bub = 1'b1;
        else if (m_valid && m_halt)         ;
        else if (!en || stall)              ;
        else if (lu)                        bub = 1'b1;
        else                                cap = 1'b1;
        w = id_word();
        @(posedge CLK);
        #1;
        if (bub) begin
            model_bubble();
            m_cnt++;
        end else if (cap) begin
            m_word  = w;
            m_valid = 1'b1;
            m_halt  = w[127];
            m_dren  = w[128];
            m_rt    = w[126:122];
        end
        check_state(tag);
    endtask

    task automatic rand_id();
        id_opfunc   = 6'($urandom);
        id_RegDst   = 2'($urandom);
        id_MemtoReg = 2'($urandom);
        id_ALUOp    = 4'($urandom);
        id_ExtOp    = 2'($urandom);
        id_ALUSrc   = 1'($urandom);
        id_RegWEN   = 1'($urandom);
        id_dWENi    = 1'($urandom);
        id_dRENi    = ($urandom_range(0, 2) == 0);
        id_halt     = 1'b0;
        id_rs       = 5'($urandom_range(0, 3));
        id_rt       = 5'($urandom_range(0, 3));
        id_rd       = 5'($urandom);
        id_shamt    = 5'($urandom);
        id_imm      = 16'($urandom);
        id_busA     = $urandom;
        id_busB     = $urandom;
        id_npc      = $urandom;
    endtask

    task automatic mid_reset(input string tag);
        #2 nRST = 1'b0;
        #1;
        model_bubble();
        m_cnt = 0;
        check_state(tag);
        chk({tag, ".lu"}, lu_stall, 1'b0);
        #2 nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0; en = 1'b0; stall = 1'b0; flush = 1'b0;
        rand_id();
        model_bubble();
        m_cnt = 0;
        repeat (2) @(posedge CLK);
        #1 check_state("reset");
        nRST = 1'b1;

        // Fill the register, then reset mid-cycle with nonzero contents.
        en = 1'b1; id_dRENi = 1'b0;
        tick("fill");
        mid_reset("midrst");

        // Directed capture.
        rand_id();
        id_busA = 32'h1234_5678; id_npc = 32'h0000_0104; id_RegWEN = 1'b1; id_dRENi = 1'b0;
        tick("cap");
        chk("cap.busA", ex_busA, 32'h1234_5678);
        chk("cap.npc", ex_npc, 32'h0000_0104);
        chk("cap.v", ex_valid, 1'b1);

        // Hold under stall, then under en low, then release.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_id(); tick("hold_st"); end
        chk("hold_st.busA", ex_busA, 32'h1234_5678);
        stall = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin rand_id(); tick("hold_en"); end
        chk("hold_en.cnt", bubble_cnt, 16'd0);
        en = 1'b1; rand_id(); id_dRENi = 1'b0;
        tick("release");

        // Flush overrides en low and stall high.
        cnt_before = m_cnt;
        en = 1'b0; stall = 1'b1; flush = 1'b1;
        tick("flush");
        chk("flush.v", ex_valid, 1'b0);
        chk("flush.wen", ex_RegWEN, 1'b0);
        chk("flush.cnt", bubble_cnt, 16'(cnt_before + 1));
        flush = 1'b0; stall = 1'b0; en = 1'b1;

        // Load-use: load with rt=8 followed by a consumer of r8.
        rand_id(); id_dRENi = 1'b1; id_rt = 5'd8; id_halt = 1'b0;
        tick("ld8");
        rand_id(); id_rt = 5'd8; id_rs = 5'd1; id_dRENi = 1'b0;
        #1;
`ifdef IDEX_LOADUSE_DETECT_EN
        chk("lu.hit", lu_stall, 1'b1);
        tick("lu_bub");
        chk("lu_bub.v", ex_valid, 1'b0);
        tick("lu_cap");
        chk("lu_cap.v", ex_valid, 1'b1);
`else
        chk("lu.off", lu_stall, 1'b0);
        tick("lu_cap");
`endif
        rand_id(); id_dRENi = 1'b1; id_rt = 5'd0;
        tick("ld0");
        rand_id(); id_rt = 5'd0; id_rs = 5'd0;
        #1 chk("lu.zero", lu_stall, 1'b0);
        tick("ld0_next");

        // Halt freeze, then flush clears it.
        rand_id(); id_halt = 1'b1; id_dRENi = 1'b0;
        flush = 1'b1; tick("pre_halt"); flush = 1'b0;
        tick("halt");
        saved_word = got_word;
        chk("halt.v", ex_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin rand_id(); tick("frozen"); end
        chk("frozen.word", got_word, saved_word);
        flush = 1'b1;
        tick("unfreeze");
        chk("unfreeze.v", ex_valid, 1'b0);

        // Saturation of the narrow counter.
        for (int i = 0; i < 5; i++) tick("sat");
        chk("sat.cnt2", s_bubble_cnt, 2'd3);
        flush = 1'b0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rand_id();
            id_halt = ($urandom_range(0, 11) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            stall   = ($urandom_range(0, 5) == 0);
            en      = ($urandom_range(0, 7) != 0);
            tick("rnd");
            if (i == 300) mid_reset("rnd_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
